// File: rtl/spi_pkt_pkg.sv
// Shared types and constants for the command byte packer: FSM states, header
// field positions and response framing.
package spi_pkt_pkg;

    typedef enum logic [2:0] {
        StHdrCollect,
        StHdrWait,
        StHdrWr,
        StDatCollect,
        StDatWr,
        StDoneWait,
        StResp
    } state_e;

    localparam int unsigned HDR_LEN_MSB = 30;
    localparam int unsigned HDR_LEN_LSB = 24;
    localparam int unsigned RESP_BYTES  = 9;
    localparam int unsigned LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [31:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/byte_shift_in.sv
// 8-to-32 MSB-first word assembler. word_done_o fires combinationally with the
// accepted 4th byte; word_next_o is the completed word at that moment.
module byte_shift_in (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic [31:0] word_next_o,
    output logic        word_done_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_next_o = {shift_q[23:0], byte_i};
        word_done_o = valid_i && (cnt_q == 2'd3);
        word_o      = shift_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        if (valid_i) begin
            shift_d = word_next_o;
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_byte_packer.sv
// Packs host command bytes into a header word plus len data words for the dword
// interface, then returns a 9-byte status/readout response.
module cmd_byte_packer
    import spi_pkt_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr,
    output logic [31:0] data_from_PC,
    input  logic        busy,
    input  logic        error,
    input  logic [63:0] readout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned GuardW   = $clog2(GUARD_CYCLES + 1);
    localparam logic [3:0]  RespLast = 4'(RESP_BYTES - 1);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        data_q, data_d;
    logic [GuardW-1:0]  guard_q, guard_d;
    logic [71:0]        resp_q, resp_d;
    logic [3:0]         resp_cnt_q, resp_cnt_d;

    logic        rx_accept, word_done, guard_done, resp_last, hdr_fire, resp_capture;
    logic [31:0] word_q, word_next;

    assign rx_accept    = rx_valid && rx_ready;
    assign guard_done   = (guard_q == GuardW'(GUARD_CYCLES));
    assign resp_last    = (resp_cnt_q == RespLast);
    assign hdr_fire     = (state_q == StHdrWait) && !busy;
    assign resp_capture = (state_q == StDoneWait) && guard_done && !busy;

    byte_shift_in u_shift (
        .clk_i       (clk_in),
        .rst_ni      (reset_n),
        .byte_i      (rx_data),
        .valid_i     (rx_accept),
        .word_o      (word_q),
        .word_next_o (word_next),
        .word_done_o (word_done)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state_q <= StHdrCollect;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHdrCollect: if (word_done) state_d = StHdrWait;
            StHdrWait:    if (!busy) state_d = StHdrWr;
            StHdrWr:      state_d = (len_q != '0) ? StDatCollect : StDoneWait;
            StDatCollect: if (word_done) state_d = StDatWr;
            StDatWr:      state_d = (len_q > LEN_W'(1)) ? StDatCollect : StDoneWait;
            StDoneWait:   if (guard_done && !busy) state_d = StResp;
            StResp:       if (tx_ready && resp_last) state_d = StHdrCollect;
            default:      state_d = StHdrCollect;
        endcase
    end

    // rx_ready is gated by reset so it is low while reset is held.
    always_comb begin
        rx_ready = reset_n && ((state_q == StHdrCollect) || (state_q == StDatCollect));
        wr       = (state_q == StHdrWr) || (state_q == StDatWr);
        tx_valid = (state_q == StResp);
    end

    always_comb begin
        len_d      = len_q;
        data_d     = data_q;
        guard_d    = guard_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;

        if (state_q == StHdrCollect && word_done) len_d = hdr_len(word_next);
        else if (state_q == StDatWr)              len_d = len_q - LEN_W'(1);

        // The assembler holds the header in HDR_WAIT; data words are taken as they complete.
        if (hdr_fire)                                 data_d = word_q;
        else if (state_q == StDatCollect && word_done) data_d = word_next;

        if (state_q != StDoneWait) guard_d = '0;
        else if (!guard_done)      guard_d = guard_q + 1'b1;

        if (resp_capture) begin
            resp_d     = {7'b0, error, readout};
            resp_cnt_d = '0;
        end else if (state_q == StResp && tx_ready) begin
            resp_d     = {resp_q[63:0], 8'h00};
            resp_cnt_d = resp_last ? 4'd0 : resp_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            len_q      <= '0;
            data_q     <= '0;
            guard_q    <= '0;
            resp_q     <= '0;
            resp_cnt_q <= '0;
        end else begin
            len_q      <= len_d;
            data_q     <= data_d;
            guard_q    <= guard_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    assign data_from_PC = data_q;
    assign tx_data      = resp_q[71:64];

endmodule

// File: tb/tb_cmd_byte_packer.sv
// Scoreboard bench for cmd_byte_packer: stimulus pushes expected words/bytes,
// a negedge monitor pops and compares what the DUT presents.
module tb_cmd_byte_packer;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr;
    logic [31:0] data_from_PC;
    logic        busy;
    logic        error;
    logic [63:0] readout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clk_in = ~clk_in;

    cmd_byte_packer #(.GUARD_CYCLES(2)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr           (wr),
        .data_from_PC (data_from_PC),
        .busy         (busy),
        .error        (error),
        .readout      (readout),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int tx_count = 0;
    int cycle = 0;
    int last_wr = -100;
    logic [31:0] last_word = '0;
    bit stall_prev = 0;
    logic [7:0] stall_byte = '0;
    int stall_mode = 0;
    int stall_at = -1;

    logic [31:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] dq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes a word or hands over a byte.
    initial begin
        logic [7:0] eb;
        forever begin
            @(negedge clk_in);
            if (reset_n) begin
                cycle++;
                if (wr) begin
                    wr_count++;
                    check("wr_spacing", 64'((cycle - last_wr) >= 2), 1);
                    last_wr = cycle;
                    check("wr_expected", 64'(exp_wr.size() != 0), 1);
                    if (exp_wr.size() != 0) begin
                        last_word = exp_wr.pop_front();
                        check("wr_word", data_from_PC, last_word);
                    end
                end else begin
                    check("data_hold", data_from_PC, last_word);
                end
                if (stall_prev) begin
                    check("tx_held_valid", tx_valid, 1);
                    check("tx_held_data", tx_data, stall_byte);
                end
                if (tx_valid) begin
                    if (tx_ready) begin
                        tx_count++;
                        check("tx_expected", 64'(exp_tx.size() != 0), 1);
                        if (exp_tx.size() != 0) begin
                            eb = exp_tx.pop_front();
                            check("tx_byte", tx_data, eb);
                        end
                        stall_prev = 0;
                    end else begin
                        stall_prev = 1;
                        stall_byte = tx_data;
                    end
                end else begin
                    stall_prev = 0;
                end
            end
        end
    end

    // Response sink: always ready, random, or one 10-cycle stall after the 4th byte.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            if (stall_mode == 2 && tx_count == stall_at) begin
                tx_ready = 1'b0;
                repeat (10) @(posedge clk_in);
                #1;
                tx_ready = 1'b1;
                stall_at = -1;
            end else if (stall_mode == 1) begin
                tx_ready = 1'($urandom_range(0, 1));
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_in);
        while (!rx_ready && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        check("rx_accept", rx_ready, 1);
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    // Reset pulse starting mid-cycle; outputs must clear at once.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_wr", wr, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_data", data_from_PC, 0);
        check("rst_tx_data", tx_data, 0);
        exp_wr.delete();
        exp_tx.delete();
        last_word  = '0;
        last_wr    = -100;
        stall_prev = 0;
        @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        #1;
        check("rx_ready_after_reset", rx_ready, 1);
    endtask

    // Reference model: words go out header-first then data in order; the response
    // is the error status byte followed by readout bytes, most significant first.
    task automatic run_txn(input logic [31:0] hdr, input int hdr_busy, input int post_busy,
                           input logic err, input logic [63:0] rd);
        int w0, t0, n;
        w0 = wr_count;
        t0 = tx_count;
        exp_wr.push_back(hdr);
        foreach (dq[i]) exp_wr.push_back(dq[i]);
        exp_tx.push_back({7'b0, err});
        for (int i = 0; i < 8; i++) exp_tx.push_back(8'(rd >> (56 - 8 * i)));
        error   = err;
        readout = rd;
        if (hdr_busy > 0) busy = 1'b1;
        send_word(hdr);
        check("rx_ready_drop", rx_ready, 0);
        if (hdr_busy > 0) begin
            repeat (hdr_busy) @(posedge clk_in);
            #1;
            check("no_wr_while_busy", 64'(wr_count - w0), 0);
            busy = 1'b0;
        end
        foreach (dq[i]) send_word(dq[i]);
        if (post_busy > 0) begin
            busy = 1'b1;
            repeat (post_busy) @(posedge clk_in);
            #1;
            busy = 1'b0;
        end
        n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
            @(posedge clk_in);
            n++;
        end
        @(posedge clk_in);
        #1;
        check("txn_wr_count", 64'(wr_count - w0), 64'(dq.size() + 1));
        check("txn_tx_count", 64'(tx_count - t0), 9);
        check("txn_idle_tx_valid", tx_valid, 0);
        check("txn_idle_rx_ready", rx_ready, 1);
    endtask

    initial begin
        int len;
        rx_valid = 1'b0;
        rx_data  = '0;
        busy     = 1'b0;
        error    = 1'b0;
        readout  = '0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_wr", wr, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_rx_ready", rx_ready, 0);
        check("reset_data", data_from_PC, 0);
        check("reset_tx_data", tx_data, 0);
        reset_n = 1'b1;
        #1;
        check("reset_release_rx_ready", rx_ready, 1);

        // Directed header len=1, DEADBEEF, busy after data.
        dq.delete();
        dq.push_back(32'hDEADBEEF);
        run_txn(32'h01001001, 0, 20, 1'b0, 64'h0123456789ABCDEF);

        // Busy high out of reset, len=0 header.
        busy = 1'b1;
        do_reset();
        dq.delete();
        run_txn(32'h80ABCDEF, 50, 0, 1'b1, {$urandom, $urandom});

        // Sink stall mid-response.
        stall_mode = 2;
        stall_at   = tx_count + 4;
        dq.delete();
        dq.push_back($urandom);
        dq.push_back($urandom);
        run_txn({1'b0, 7'd2, 24'h123456}, 0, 3, 1'b0, {$urandom, $urandom});
        stall_mode = 0;

        // Reset after two data bytes; the following bytes form a fresh header.
        exp_wr.push_back(32'h01AA5500);
        send_word(32'h01AA5500);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        dq.delete();
        run_txn(32'h00C0FFEE, 0, 0, 1'b1, 64'hFEDCBA9876543210);

        // Maximum length, back-to-back bytes.
        dq.delete();
        for (int i = 0; i < 127; i++) dq.push_back($urandom);
        run_txn({1'b1, 7'd127, 24'h0F0F0F}, 0, 0, 1'b0, {$urandom, $urandom});

        // Random transactions with a randomly throttled sink.
        stall_mode = 1;
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(0, 5);
            dq.delete();
            for (int i = 0; i < len; i++) dq.push_back($urandom);
            run_txn({1'($urandom), 7'(len), 24'($urandom)}, $urandom_range(0, 5),
                    $urandom_range(0, 10), 1'($urandom), {$urandom, $urandom});
        end
        stall_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
